// File: rtl/key_scan_pkg.sv
// Shared types for the key matrix scanner: event record and emission sequencer states.
package key_scan_pkg;

    localparam int NUM_COLS_DEF = 4;
    localparam int NUM_ROWS_DEF = 4;
    localparam int KEY_W        = $clog2(NUM_COLS_DEF * NUM_ROWS_DEF);

    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic             press;
    } key_evt_t;

    typedef enum logic {
        EMIT_IDLE,
        EMIT_SCAN
    } emit_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO of key events; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module key_evt_fifo
    import key_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  key_evt_t din,
    input  logic     pop,
    output key_evt_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    key_evt_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    // Empty reads as zero so the head fields are defined out of reset.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-strobed key matrix scanner: per-key debounce, held-key bitmap and a
// press/release event queue drained over valid/ready.
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int NUM_COLS       = NUM_COLS_DEF,
    parameter int NUM_ROWS       = NUM_ROWS_DEF,
    parameter int SCAN_TICKS     = 27000,
    parameter int SETTLE_TICKS   = 8,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int EVT_DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    output logic [NUM_COLS-1:0]                   col_drive,
    input  logic [NUM_ROWS-1:0]                   row_sense,
    output logic [NUM_COLS*NUM_ROWS-1:0]          key_state,
    output logic                                  evt_valid,
    input  logic                                  evt_ready,
    output logic [$clog2(NUM_COLS*NUM_ROWS)-1:0]  evt_code,
    output logic                                  evt_press,
    output logic                                  evt_overflow,
    input  logic                                  clr_overflow
);

    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int SLOT_W   = $clog2(SCAN_TICKS);
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);

    // Row synchronizer; idle rows are pulled up, so reset to all ones.
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_ROWS-1:0] raw_rows;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_sense;
            row_sync <= row_meta;
        end
    end

    assign raw_rows = ~row_sync;

    logic [SLOT_W-1:0] slot_cnt;
    logic [COL_W-1:0]  col_idx;
    logic [COL_W-1:0]  col_nxt;
    logic              slot_wrap;
    logic              sample;

    assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_TICKS - 1));
    assign sample    = (slot_cnt == SLOT_W'(SETTLE_TICKS));

    always_comb begin
        col_nxt = col_idx;
        if (slot_wrap)
            col_nxt = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
    end

    // col_drive is registered from col_nxt so it stays all-ones until the
    // first clock after reset and then tracks col_idx exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            col_idx   <= '0;
            col_drive <= '1;
        end else begin
            slot_cnt  <= slot_wrap ? '0 : slot_cnt + 1'b1;
            col_idx   <= col_nxt;
            col_drive <= ~(NUM_COLS'(1) << col_nxt);
        end
    end

    logic [NUM_KEYS-1:0]            at_col;
    logic [NUM_KEYS-1:0]            differ;
    logic [NUM_KEYS-1:0]            flip;
    logic [NUM_KEYS-1:0][CNT_W-1:0] db_cnt;
    logic [NUM_ROWS-1:0]            chg_now;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        localparam int C = k / NUM_ROWS;
        localparam int R = k % NUM_ROWS;
        assign at_col[k] = sample && (col_idx == COL_W'(C));
        assign differ[k] = raw_rows[R] != key_state[k];
        assign flip[k]   = at_col[k] && differ[k] &&
                           (db_cnt[k] == CNT_W'(DEBOUNCE_SCANS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            key_state <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (at_col[k]) begin
                    if (!differ[k]) begin
                        db_cnt[k] <= '0;
                    end else if (flip[k]) begin
                        db_cnt[k]    <= '0;
                        key_state[k] <= ~key_state[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Only the sampled column can flip, so fold flips down onto row positions.
    always_comb begin
        chg_now = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (flip[k]) chg_now[k % NUM_ROWS] = 1'b1;
    end

    emit_state_t         state;
    emit_state_t         state_nxt;
    logic [NUM_ROWS-1:0] pend;
    logic [NUM_ROWS-1:0] pend_nxt;
    logic [COL_W-1:0]    emit_col;
    logic [ROW_W-1:0]    sel_row;
    logic [KEY_W-1:0]    issue_code;
    logic                issue;
    logic                push_q;
    key_evt_t            evt_q;

    always_comb begin
        sel_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--)
            if (pend[r]) sel_row = ROW_W'(r);
    end

    assign issue_code = KEY_W'(int'(emit_col) * NUM_ROWS + int'(sel_row));

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        issue     = 1'b0;
        case (state)
            EMIT_IDLE: begin
                if (|chg_now) begin
                    pend_nxt  = chg_now;
                    state_nxt = EMIT_SCAN;
                end
            end
            EMIT_SCAN: begin
                issue    = 1'b1;
                pend_nxt = pend & ~(NUM_ROWS'(1) << sel_row);
                if (pend_nxt == '0) state_nxt = EMIT_IDLE;
            end
            default: state_nxt = EMIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMIT_IDLE;
            pend     <= '0;
            emit_col <= '0;
            push_q   <= 1'b0;
            evt_q    <= '0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            push_q <= issue;
            if (state == EMIT_IDLE && |chg_now) emit_col <= col_idx;
            if (issue) begin
                evt_q.code  <= issue_code;
                evt_q.press <= key_state[issue_code];
            end
        end
    end

    key_evt_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     drop;

    key_evt_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (evt_q),
        .pop   (evt_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head.code;
    assign evt_press = head.press;
    assign drop      = push_q && fifo_full && !evt_ready;

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            evt_overflow <= 1'b0;
        else if (drop)         evt_overflow <= 1'b1;
        else if (clr_overflow) evt_overflow <= 1'b0;
    end

endmodule
